// File: rtl/e_sd_cmd_tx_pkg.sv
// e_sd_cmd_tx_pkg: frame geometry, CRC7 polynomial and FSM encoding for the SD command path.
package e_sd_cmd_tx_pkg;
    localparam logic [5:0] FRAME_LEN = 6'd48;
    localparam logic [5:0] HDR_BITS  = 6'd40;
    localparam logic [5:0] CRC_LAST  = 6'd46;
    localparam logic [5:0] END_BIT   = 6'd47;
    localparam logic [6:0] CRC7_POLY = 7'h09;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;
endpackage

// File: rtl/e_sd_cmd_tx_crc7.sv
// e_crc7_ser: bit-serial CRC7 (x^7+x^3+1), shared by the command transmitter and response receiver.
module e_crc7_ser
    import e_sd_cmd_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);
    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        fb    = din ^ crc_q[6];
        crc_d = clr ? 7'd0 : en ? ({crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0)) : crc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) crc_q <= 7'd0;
        else     crc_q <= crc_d;
    end

    assign crc = crc_q;
endmodule

// File: rtl/e_sd_cmd_tx.sv
// e_sd_cmd_tx: serializes a 48-bit SD command frame onto CMD, one bit per SD clock falling-edge strobe,
// then holds the bus released for NCC_CLKS strobes before accepting another command.
module e_sd_cmd_tx
    import e_sd_cmd_tx_pkg::*;
#(
    parameter int NCC_CLKS = 8
) (
    input  logic        sd_clk_2x,
    input  logic        rst,
    input  logic        sd_clk_fall_p,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        cmd_abort,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        busy,
    output logic        done_p,
    output logic        start_err_p
);
    localparam logic [3:0] NCC = 4'(NCC_CLKS);

    logic [1:0]  state_q, state_d;
    logic [39:0] shreg_q, shreg_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        cmd_out_q, cmd_out_d;
    logic        cmd_oe_q, cmd_oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        serr_q, serr_d;
    logic        crc_clr, crc_en;
    logic [6:0]  crc;
    logic [5:0]  crc_sel;

    e_crc7_ser u_crc (
        .clk(sd_clk_2x),
        .rst(rst),
        .clr(crc_clr),
        .en(crc_en),
        .din(shreg_q[39]),
        .crc(crc)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        cmd_out_d = cmd_out_q;
        cmd_oe_d  = cmd_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        serr_d    = cmd_start && state_q != ST_IDLE;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        crc_sel   = CRC_LAST - bit_cnt_q;
        case (state_q)
            ST_IDLE: if (cmd_start) begin
                shreg_d   = {2'b01, cmd_index, cmd_arg};
                bit_cnt_d = 6'd0;
                crc_clr   = 1'b1;
                busy_d    = 1'b1;
                state_d   = ST_ARMED;
            end
            ST_ARMED, ST_SHIFT: if (cmd_abort) begin
                cmd_oe_d  = 1'b0;
                cmd_out_d = 1'b1;
                gap_cnt_d = NCC;
                state_d   = ST_GAP;
            end else if (sd_clk_fall_p) begin
                // bit_cnt_q is the number of bits already launched, so it indexes the next bit
                state_d   = ST_SHIFT;
                bit_cnt_d = (bit_cnt_q == FRAME_LEN) ? FRAME_LEN : bit_cnt_q + 6'd1;
                if (bit_cnt_q < HDR_BITS) begin
                    cmd_oe_d  = 1'b1;
                    cmd_out_d = shreg_q[39];
                    shreg_d   = {shreg_q[38:0], 1'b0};
                    crc_en    = 1'b1;
                end else if (bit_cnt_q <= CRC_LAST) begin
                    cmd_out_d = crc[crc_sel[2:0]];
                end else if (bit_cnt_q == END_BIT) begin
                    cmd_out_d = 1'b1;
                end else begin
                    cmd_oe_d  = 1'b0;
                    cmd_out_d = 1'b1;
                    done_d    = 1'b1;
                    gap_cnt_d = NCC;
                    state_d   = ST_GAP;
                end
            end
            default: if (sd_clk_fall_p) begin
                gap_cnt_d = gap_cnt_q - 4'd1;
                if (gap_cnt_q == 4'd1) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge sd_clk_2x) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= 40'd0;
            bit_cnt_q <= 6'd0;
            gap_cnt_q <= 4'd0;
            cmd_out_q <= 1'b1;
            cmd_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            cmd_out_q <= cmd_out_d;
            cmd_oe_q  <= cmd_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            serr_q    <= serr_d;
        end
    end

    assign cmd_out     = cmd_out_q;
    assign cmd_oe      = cmd_oe_q;
    assign busy        = busy_q;
    assign done_p      = done_q;
    assign start_err_p = serr_q;
endmodule
